// File: rtl/adc_pkg.sv
// adc_pkg: state encoding, default parameters and sclk-rate presets
// shared by the adc_sampler block and its sub-modules.
package adc_pkg;

  typedef enum logic [1:0] {
    ST_CAL,
    ST_IDLE,
    ST_CONV,
    ST_QUIET
  } adc_state_e;

  localparam int DEF_NUM_CH       = 3;
  localparam int DEF_DATA_WIDTH   = 12;
  localparam int DEF_FRAME_BITS   = 16;
  localparam int DEF_LEAD_ZEROS   = 4;
  localparam int DEF_SCLK_DIV     = 1;
  localparam int DEF_CAL_CYCLES   = 32;
  localparam int DEF_QUIET_CYCLES = 2;

  localparam int SCLK_DIV_FAST = 1;
  localparam int SCLK_DIV_MID  = 2;
  localparam int SCLK_DIV_SLOW = 4;

  localparam int CNT_W = 16;

endpackage

// File: rtl/adc_sampler_if.sv
// adc_sampler_if: request, serial and result signals of adc_sampler.
// Carries frame_err only when ADC_FRAME_CHECK_EN is defined.
interface adc_sampler_if
  import adc_pkg::*;
#(
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) ();

  logic                         start;
  logic                         cont_en;
  logic                         recalibrate;
  logic [NUM_CH-1:0]            sdo;
  logic                         cs;
  logic                         sclk;
  logic [NUM_CH*DATA_WIDTH-1:0] data;
  logic                         valid;
  logic                         busy;
  logic                         cal_done;
`ifdef ADC_FRAME_CHECK_EN
  logic [NUM_CH-1:0]            frame_err;

  modport master (
    input  start, cont_en, recalibrate, sdo,
    output cs, sclk, data, valid, busy, cal_done, frame_err
  );

  modport slave (
    output start, cont_en, recalibrate, sdo,
    input  cs, sclk, data, valid, busy, cal_done, frame_err
  );
`else
  modport master (
    input  start, cont_en, recalibrate, sdo,
    output cs, sclk, data, valid, busy, cal_done
  );

  modport slave (
    output start, cont_en, recalibrate, sdo,
    input  cs, sclk, data, valid, busy, cal_done
  );
`endif

endinterface

// File: rtl/adc_shifter.sv
// adc_shifter: per-channel MSB-first shift register and result capture.
// With ADC_FRAME_CHECK_EN, a nonzero leading bit blocks the capture.
module adc_shifter #(
  parameter int DATA_WIDTH = 12
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  clr_i,
  input  logic                  shift_i,
  input  logic                  capture_i,
  input  logic                  sdo_i,
`ifdef ADC_FRAME_CHECK_EN
  input  logic                  lead_i,
  output logic                  err_o,
`endif
  output logic [DATA_WIDTH-1:0] data_o
);

  logic [DATA_WIDTH-1:0] sr_q, sr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  take;

`ifdef ADC_FRAME_CHECK_EN
  logic err_q, err_d;
  logic ferr_q, ferr_d;

  always_comb begin
    err_d  = err_q;
    if (clr_i)
      err_d = 1'b0;
    else if (lead_i && sdo_i)
      err_d = 1'b1;
    ferr_d = capture_i && err_d;
    take   = capture_i && !err_d;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      err_q  <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      err_q  <= err_d;
      ferr_q <= ferr_d;
    end
  end

  assign err_o = ferr_q;
`else
  assign take = capture_i;
`endif

  // the final capture sees this cycle's shift so the last data bit may
  // also be the last bit of the frame
  always_comb begin
    sr_d = sr_q;
    if (clr_i)
      sr_d = '0;
    else if (shift_i)
      sr_d = {sr_q[DATA_WIDTH-2:0], sdo_i};
    data_d = take ? sr_d : data_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sr_q   <= '0;
      data_q <= '0;
    end else begin
      sr_q   <= sr_d;
      data_q <= data_d;
    end
  end

  assign data_o = data_q;

endmodule

// File: rtl/adc_sampler.sv
// adc_sampler: drives shared cs/sclk to NUM_CH serial ADCs, calibrates,
// samples frames. Define ADC_FRAME_CHECK_EN to add frame_err reporting.
module adc_sampler
  import adc_pkg::*;
#(
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int FRAME_BITS   = DEF_FRAME_BITS,
  parameter int LEAD_ZEROS   = DEF_LEAD_ZEROS,
  parameter int SCLK_DIV     = DEF_SCLK_DIV,
  parameter int CAL_CYCLES   = DEF_CAL_CYCLES,
  parameter int QUIET_CYCLES = DEF_QUIET_CYCLES
) (
  input logic           clk,
  input logic           reset,
  adc_sampler_if.master bus
);

  if (LEAD_ZEROS + DATA_WIDTH > FRAME_BITS || SCLK_DIV < 1) begin : g_bad_cfg
    $error("adc_sampler: LEAD_ZEROS+DATA_WIDTH > FRAME_BITS or SCLK_DIV < 1");
  end

  localparam logic [CNT_W-1:0] DIV_LAST  = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] CAL_LAST  = CNT_W'(CAL_CYCLES - 1);
  localparam logic [CNT_W-1:0] FRM_LAST  = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] QUIET_END = CNT_W'(QUIET_CYCLES);
  localparam logic [CNT_W-1:0] DAT_LO    = CNT_W'(LEAD_ZEROS);
  localparam logic [CNT_W-1:0] DAT_HI    = CNT_W'(LEAD_ZEROS + DATA_WIDTH);

  adc_state_e       state_q, state_d;
  logic             cs_q, cs_d;
  logic             sclk_q, sclk_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] bit_q, bit_d;
  logic [CNT_W-1:0] quiet_q, quiet_d;
  logic             pend_q, pend_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             go_cal, go_conv;
  logic             clr, sample, capture, shift_en;
  logic [CNT_W-1:0] last_bit;

  always_comb begin
    state_d  = state_q;
    cs_d     = cs_q;
    sclk_d   = sclk_q;
    div_d    = div_q;
    bit_d    = bit_q;
    quiet_d  = quiet_q;
    pend_d   = pend_q;
    done_d   = done_q;
    valid_d  = 1'b0;
    go_cal   = 1'b0;
    go_conv  = 1'b0;
    clr      = 1'b0;
    capture  = 1'b0;
    last_bit = (state_q == ST_CAL) ? CAL_LAST : FRM_LAST;
    sample   = (state_q == ST_CONV) && !cs_q && sclk_q
               && (div_q == '0);

    unique case (state_q)
      ST_CAL, ST_CONV: begin
        if (state_q == ST_CONV && bus.recalibrate)
          pend_d = 1'b1;
        // cs still high only in the first CAL cycle after reset
        if (cs_q) begin
          cs_d   = 1'b0;
          sclk_d = 1'b0;
          div_d  = '0;
          bit_d  = '0;
        end else if (div_q == DIV_LAST) begin
          div_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else if (bit_q == last_bit) begin
            cs_d    = 1'b1;
            sclk_d  = 1'b1;
            quiet_d = '0;
            state_d = ST_QUIET;
            if (state_q == ST_CAL) begin
              done_d = 1'b1;
            end else begin
              valid_d = 1'b1;
              capture = 1'b1;
            end
          end else begin
            sclk_d = 1'b0;
            bit_d  = bit_q + 1'b1;
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
      ST_QUIET: begin
        if (bus.recalibrate)
          pend_d = 1'b1;
        if (quiet_q == QUIET_END) begin
          if (pend_q || bus.recalibrate)
            go_cal = 1'b1;
          else if (bus.cont_en)
            go_conv = 1'b1;
          else
            state_d = ST_IDLE;
        end else begin
          quiet_d = quiet_q + 1'b1;
        end
      end
      ST_IDLE: begin
        if (bus.recalibrate)
          go_cal = 1'b1;
        else if (bus.start || bus.cont_en)
          go_conv = 1'b1;
      end
      default: state_d = ST_CAL;
    endcase

    if (go_cal) begin
      state_d = ST_CAL;
      pend_d  = 1'b0;
      done_d  = 1'b0;
    end
    if (go_conv) begin
      state_d = ST_CONV;
      clr     = 1'b1;
    end
    if (go_cal || go_conv) begin
      cs_d   = 1'b0;
      sclk_d = 1'b0;
      div_d  = '0;
      bit_d  = '0;
    end
    busy_d = (state_d != ST_IDLE);
  end

  assign shift_en = sample && (bit_q >= DAT_LO) && (bit_q < DAT_HI);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_CAL;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b1;
      div_q   <= '0;
      bit_q   <= '0;
      quiet_q <= '0;
      pend_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      quiet_q <= quiet_d;
      pend_q  <= pend_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

`ifdef ADC_FRAME_CHECK_EN
  logic lead_en;
  assign lead_en = sample && (bit_q < DAT_LO);
`endif

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    adc_shifter #(
      .DATA_WIDTH(DATA_WIDTH)
    ) u_shifter (
      .clk_i    (clk),
      .reset_i  (reset),
      .clr_i    (clr),
      .shift_i  (shift_en),
      .capture_i(capture),
      .sdo_i    (bus.sdo[i]),
`ifdef ADC_FRAME_CHECK_EN
      .lead_i   (lead_en),
      .err_o    (bus.frame_err[i]),
`endif
      .data_o   (bus.data[i*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  assign bus.cs       = cs_q;
  assign bus.sclk     = sclk_q;
  assign bus.valid    = valid_q;
  assign bus.busy     = busy_q;
  assign bus.cal_done = done_q;

endmodule

// File: tb/tb_adc_sampler.sv
// tb_adc_sampler: randomized frames from a behavioural ADC model,
// checked against expected timing and results per scenario.
module tb_adc_sampler;

  localparam int NCH = 3;
  localparam int DW  = 12;
  localparam int FB  = 16;
  localparam int LZ  = 4;
  localparam int SD  = 2;
  localparam int CAL = 32;
  localparam int QC  = 2;
  localparam int FRAME_CYC = 2 * SD * FB;
  localparam int CAL_CYC   = 2 * SD * CAL;
  localparam int PERIOD    = FRAME_CYC + 1 + QC;

  logic clk = 1'b0;
  logic reset = 1'b1;

  adc_sampler_if #(.NUM_CH(NCH), .DATA_WIDTH(DW)) bus ();

  adc_sampler #(
    .NUM_CH(NCH), .DATA_WIDTH(DW), .FRAME_BITS(FB),
    .LEAD_ZEROS(LZ), .SCLK_DIV(SD), .CAL_CYCLES(CAL),
    .QUIET_CYCLES(QC)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int n_cslow, n_rise, n_valid;
  logic sclk_prev = 1'b1;
  int fc = 0;

  logic [FB-1:0] word [NCH];
  logic [DW-1:0] exp_data [NCH];
`ifdef ADC_FRAME_CHECK_EN
  logic [NCH-1:0] exp_err;
`endif

  // ADC model: bit k of the frame is on sdo for the whole k-th sclk period
  always @(posedge clk) begin
    #1;
    if (bus.cs) fc = 0;
    else        fc++;
    for (int c = 0; c < NCH; c++) begin
      int k;
      k = (fc - 1) / (2 * SD);
      bus.sdo[c] = (bus.cs || k >= FB) ? 1'b0 : word[c][FB-1-k];
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (bus.valid) n_valid++;
    if (!bus.cs) n_cslow++;
    if (bus.sclk && !sclk_prev) n_rise++;
    sclk_prev = bus.sclk;
  endtask

  task automatic zero_counts();
    n_cslow = 0;
    n_rise  = 0;
    n_valid = 0;
  endtask

  task automatic wait_valid(input int limit, output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_done(input logic lvl, input int limit,
                           output int lat);
    lat = -1;
    for (int i = 1; i <= limit; i++) begin
      step();
      if (bus.cal_done === lvl) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic new_words();
    for (int c = 0; c < NCH; c++) begin
      word[c] = FB'($urandom);
`ifdef ADC_FRAME_CHECK_EN
      word[c][FB-1 -: LZ] = '0;
`endif
    end
  endtask

  task automatic commit();
    for (int c = 0; c < NCH; c++) begin
`ifdef ADC_FRAME_CHECK_EN
      exp_err[c] = (word[c][FB-1 -: LZ] != '0);
      if (!exp_err[c])
`endif
        exp_data[c] = word[c][FB-1-LZ -: DW];
    end
  endtask

  task automatic test_reset();
    bus.start = 1'b0;
    bus.cont_en = 1'b0;
    bus.recalibrate = 1'b0;
    for (int c = 0; c < NCH; c++) exp_data[c] = '0;
    step();
    step();
    n_vec++;
    if (bus.cs !== 1'b1) begin
      n_bad++; $display("FAIL reset_cs got %b want 1", bus.cs);
    end
    n_vec++;
    if (bus.sclk !== 1'b1) begin
      n_bad++; $display("FAIL reset_sclk got %b want 1", bus.sclk);
    end
    n_vec++;
    if (bus.valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid got %b want 0", bus.valid);
    end
    n_vec++;
    if (bus.busy !== 1'b0) begin
      n_bad++; $display("FAIL reset_busy got %b want 0", bus.busy);
    end
    n_vec++;
    if (bus.cal_done !== 1'b0) begin
      n_bad++; $display("FAIL reset_cal_done got %b want 0", bus.cal_done);
    end
    n_vec++;
    if (bus.data !== '0) begin
      n_bad++; $display("FAIL reset_data got %h want 0", bus.data);
    end
  endtask

  task automatic test_cal();
    int lat;
    reset = 1'b0;
    zero_counts();
    wait_done(1'b1, CAL_CYC + 20, lat);
    n_vec++;
    if (lat < 0) begin
      n_bad++; $display("FAIL cal_done_timeout got none want rise");
    end
    n_vec++;
    if (n_cslow !== CAL_CYC) begin
      n_bad++; $display("FAIL cal_cs_low got %0d want %0d", n_cslow, CAL_CYC);
    end
    n_vec++;
    if (n_rise !== CAL) begin
      n_bad++; $display("FAIL cal_sclk_periods got %0d want %0d", n_rise, CAL);
    end
    repeat (QC + 1) step();
    n_vec++;
    if (bus.busy !== 1'b0 || bus.cal_done !== 1'b1) begin
      n_bad++;
      $display("FAIL cal_idle got busy=%b done=%b want busy=0 done=1",
               bus.busy, bus.cal_done);
    end
    n_vec++;
    if (n_valid !== 0) begin
      n_bad++; $display("FAIL cal_valid got %0d pulses want 0", n_valid);
    end
  endtask

  task automatic test_single(input int iters);
    int lat, pre;
    for (int it = 0; it < iters; it++) begin
      new_words();
      if (it == 0) begin
        word[0] = 16'h0AB3;
        word[2] = 16'h0FFF;
      end
      repeat ($urandom_range(0, 3)) step();
      zero_counts();
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      pre = 0;
      if (it[0]) begin
        pre = $urandom_range(2, 40);
        repeat (pre - 1) step();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
      end
      wait_valid(FRAME_CYC + 10, lat);
      commit();
      n_vec++;
      if (lat !== FRAME_CYC - pre) begin
        n_bad++;
        $display("FAIL single_latency got %0d want %0d", lat, FRAME_CYC - pre);
      end
      for (int c = 0; c < NCH; c++) begin
        n_vec++;
        if (bus.data[c*DW +: DW] !== exp_data[c]) begin
          n_bad++;
          $display("FAIL single_data ch%0d got %h want %h",
                   c, bus.data[c*DW +: DW], exp_data[c]);
        end
      end
      n_vec++;
      if (bus.cs !== 1'b1 || n_cslow !== FRAME_CYC || n_rise !== FB) begin
        n_bad++;
        $display("FAIL single_frame got cs=%b low=%0d rises=%0d want 1 %0d %0d",
                 bus.cs, n_cslow, n_rise, FRAME_CYC, FB);
      end
      step();
      n_vec++;
      if (bus.valid !== 1'b0) begin
        n_bad++; $display("FAIL single_pulse got valid=%b want 0", bus.valid);
      end
      repeat (QC + 2) step();
      n_vec++;
      if (bus.busy !== 1'b0 || n_valid !== 1) begin
        n_bad++;
        $display("FAIL single_no_queue got busy=%b valids=%0d want 0 1",
                 bus.busy, n_valid);
      end
    end
  endtask

  task automatic test_cont();
    int lat;
    new_words();
    zero_counts();
    bus.cont_en = 1'b1;
    step();
    for (int f = 0; f < 3; f++) begin
      wait_valid(PERIOD + 10, lat);
      if (f == 2) bus.cont_en = 1'b0;
      commit();
      n_vec++;
      if (lat !== ((f == 0) ? FRAME_CYC : PERIOD)) begin
        n_bad++;
        $display("FAIL cont_spacing f%0d got %0d want %0d",
                 f, lat, (f == 0) ? FRAME_CYC : PERIOD);
      end
      n_vec++;
      if (n_cslow !== FRAME_CYC) begin
        n_bad++;
        $display("FAIL cont_cs_low f%0d got %0d want %0d", f, n_cslow, FRAME_CYC);
      end
      for (int c = 0; c < NCH; c++) begin
        n_vec++;
        if (bus.data[c*DW +: DW] !== exp_data[c]) begin
          n_bad++;
          $display("FAIL cont_data f%0d ch%0d got %h want %h",
                   f, c, bus.data[c*DW +: DW], exp_data[c]);
        end
      end
      new_words();
      n_cslow = 0;
    end
    repeat (QC + 2) step();
    n_vec++;
    if (bus.busy !== 1'b0 || n_valid !== 3 || n_cslow !== 0) begin
      n_bad++;
      $display("FAIL cont_stop got busy=%b valids=%0d low=%0d want 0 3 0",
               bus.busy, n_valid, n_cslow);
    end
  endtask

  task automatic test_recal_mid();
    int lat;
    new_words();
    zero_counts();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (2 * SD * 8) step();
    bus.recalibrate = 1'b1;
    step();
    bus.recalibrate = 1'b0;
    wait_valid(FRAME_CYC, lat);
    commit();
    n_vec++;
    if (lat !== FRAME_CYC - 2 * SD * 8 - 1) begin
      n_bad++;
      $display("FAIL recal_valid got %0d want %0d", lat, FRAME_CYC - 2*SD*8 - 1);
    end
    for (int c = 0; c < NCH; c++) begin
      n_vec++;
      if (bus.data[c*DW +: DW] !== exp_data[c]) begin
        n_bad++;
        $display("FAIL recal_data ch%0d got %h want %h",
                 c, bus.data[c*DW +: DW], exp_data[c]);
      end
    end
    zero_counts();
    wait_done(1'b0, QC + 5, lat);
    n_vec++;
    if (lat < 0) begin
      n_bad++; $display("FAIL recal_done_low got none want fall");
    end
    wait_done(1'b1, CAL_CYC + 10, lat);
    n_vec++;
    if (lat < 0 || n_cslow !== CAL_CYC || n_valid !== 0) begin
      n_bad++;
      $display("FAIL recal_cal got lat=%0d low=%0d valids=%0d want low=%0d 0",
               lat, n_cslow, n_valid, CAL_CYC);
    end
    repeat (QC + 1) step();
  endtask

  task automatic test_recal_priority();
    int lat;
    zero_counts();
    bus.start = 1'b1;
    bus.recalibrate = 1'b1;
    step();
    bus.start = 1'b0;
    bus.recalibrate = 1'b0;
    n_vec++;
    if (bus.cal_done !== 1'b0 || bus.cs !== 1'b0) begin
      n_bad++;
      $display("FAIL prio_enter_cal got done=%b cs=%b want 0 0",
               bus.cal_done, bus.cs);
    end
    wait_done(1'b1, CAL_CYC + 10, lat);
    n_vec++;
    if (lat < 0 || n_valid !== 0 || n_rise !== CAL) begin
      n_bad++;
      $display("FAIL prio_cal got lat=%0d valids=%0d rises=%0d want 0 %0d",
               lat, n_valid, n_rise, CAL);
    end
    repeat (QC + 1) step();
  endtask

`ifdef ADC_FRAME_CHECK_EN
  task automatic test_frame_check();
    int lat;
    new_words();
    word[1][FB-1 -: LZ] = 4'b0100;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_valid(FRAME_CYC + 10, lat);
    commit();
    n_vec++;
    if (lat < 0 || bus.frame_err !== exp_err) begin
      n_bad++;
      $display("FAIL frame_err got %b want %b", bus.frame_err, exp_err);
    end
    for (int c = 0; c < NCH; c++) begin
      n_vec++;
      if (bus.data[c*DW +: DW] !== exp_data[c]) begin
        n_bad++;
        $display("FAIL frame_chk_data ch%0d got %h want %h",
                 c, bus.data[c*DW +: DW], exp_data[c]);
      end
    end
    repeat (QC + 2) step();
  endtask
`endif

  task automatic test_reset_mid();
    int lat;
    new_words();
    zero_counts();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (2 * SD * 5) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int c = 0; c < NCH; c++) exp_data[c] = '0;
    n_vec++;
    if (bus.cs !== 1'b1 || bus.sclk !== 1'b1) begin
      n_bad++;
      $display("FAIL abort_pins got cs=%b sclk=%b want 1 1", bus.cs, bus.sclk);
    end
    n_vec++;
    if (bus.valid !== 1'b0 || bus.busy !== 1'b0 || bus.cal_done !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_flags got v=%b b=%b d=%b want 0 0 0",
               bus.valid, bus.busy, bus.cal_done);
    end
    n_vec++;
    if (bus.data !== '0) begin
      n_bad++; $display("FAIL abort_data got %h want 0", bus.data);
    end
    wait_done(1'b1, CAL_CYC + 20, lat);
    n_vec++;
    if (lat < 0 || n_valid !== 0) begin
      n_bad++;
      $display("FAIL abort_recover got lat=%0d valids=%0d want 0", lat, n_valid);
    end
  endtask

  initial begin
    for (int c = 0; c < NCH; c++) word[c] = '0;
    bus.sdo = '0;
    test_reset();
    test_cal();
    test_single(7);
    test_cont();
    test_recal_mid();
    test_recal_priority();
`ifdef ADC_FRAME_CHECK_EN
    test_frame_check();
`endif
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
